// File: rtl/sample_fifo_pkg.sv
// Shared definitions for the sample FIFO: pointer/count width helpers,
// the wrap-around pointer increment and the occupancy status record.
package sample_fifo_pkg;

  // Parameter defaults used by the top level.
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 3;

  // Pointer width for a given depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Advance a circular pointer by one, wrapping from depth-1 back to 0.
  // Works for any depth, not only powers of two.
  function automatic int unsigned next_ptr(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

  // Registered occupancy status, all derived from the same count value.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Status seen straight out of reset (empty buffer).
  localparam fifo_status_t STATUS_RESET = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular storage pointer: advances by one when enabled and wraps from
// DEPTH-1 to 0. Used once for the producer side and once for the consumer.
module fifo_wrap_ptr
  import sample_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  // Wrap-around successor of the current pointer.
  always_comb begin
    ptr_next = PTR_W'(next_ptr(32'(ptr_reg), 32'(DEPTH)));
  end

  // Pointer register; cleared immediately when reset goes low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else if (enable) begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/sample_fifo.sv
// Signed-sample FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an output-valid strobe.
// Every output is a register; inputs only reach outputs through an edge.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ALMOST_FULL  = DEPTH - 1,
  parameter int ALMOST_EMPTY = 1,
  localparam int PTR_W       = ptr_width(DEPTH),
  localparam int CNT_W       = cnt_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] in,
  input  logic                    w_enable,
  input  logic                    r_enable,
  input  logic                    clear_flags,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL  = CNT_W'(ALMOST_FULL);
  localparam logic [CNT_W-1:0] AE_LEVEL  = CNT_W'(ALMOST_EMPTY);

  // Sample storage; intentionally not reset so it maps onto block RAM.
  logic signed [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;

  logic [CNT_W-1:0]        count_reg;
  logic [CNT_W-1:0]        count_next;
  fifo_status_t            status_reg;
  fifo_status_t            status_next;
  logic signed [WIDTH-1:0] out_reg;
  logic                    out_valid_reg;
  logic                    overflow_reg;
  logic                    overflow_next;
  logic                    underflow_reg;
  logic                    underflow_next;

  logic rd_accept;
  logic wr_accept;

  // Read needs data present. A write into a full buffer is still taken
  // when a read frees a slot in the same cycle; an empty buffer never
  // passes the incoming sample straight through to the output.
  always_comb begin
    rd_accept = r_enable && !status_reg.empty;
    wr_accept = w_enable && (!status_reg.full || rd_accept);
  end

  fifo_wrap_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk    (clk),
    .reset  (reset),
    .enable (wr_accept),
    .ptr    (wr_ptr)
  );

  fifo_wrap_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk    (clk),
    .reset  (reset),
    .enable (rd_accept),
    .ptr    (rd_ptr)
  );

  // Store accepted samples at the producer pointer.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= in;
    end
  end

  // Registered read port and its one-cycle valid strobe; out holds
  // its previous value whenever no read is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= rd_accept;
      if (rd_accept) begin
        out_reg <= mem[rd_ptr];
      end
    end
  end

  // Next occupancy, status derived from it, and sticky error flags
  // (a new error in the same cycle as clear_flags keeps the flag set).
  always_comb begin
    count_next = count_reg;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    status_next.full         = (count_next == CNT_DEPTH);
    status_next.empty        = (count_next == '0);
    status_next.almost_full  = (count_next >= AF_LEVEL);
    status_next.almost_empty = (count_next <= AE_LEVEL);

    overflow_next  = (w_enable && !wr_accept) || (overflow_reg && !clear_flags);
    underflow_next = (r_enable && !rd_accept) || (underflow_reg && !clear_flags);
  end

  // Occupancy, status and error flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg     <= '0;
      status_reg    <= STATUS_RESET;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      status_reg    <= status_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign out          = out_reg;
  assign out_valid    = out_valid_reg;
  assign count        = count_reg;
  assign full         = status_reg.full;
  assign empty        = status_reg.empty;
  assign almost_full  = status_reg.almost_full;
  assign almost_empty = status_reg.almost_empty;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sample_fifo.sv
// Bench for sample_fifo: a DEPTH=3 and a DEPTH=5 instance share stimulus;
// a queue-based reference model tracks whichever instance is under test.
module tb_sample_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic signed [7:0] din;
  logic              w_en, r_en, clr;

  logic signed [7:0] out_a, out_b;
  logic              vld_a, vld_b;
  logic [1:0]        cnt_a;
  logic [2:0]        cnt_b;
  logic full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic full_b, empty_b, af_b, ae_b, ovf_b, unf_b;

  sample_fifo #(.WIDTH(8), .DEPTH(3)) u_dut_a (
    .clk(clk), .reset(reset), .in(din), .w_enable(w_en), .r_enable(r_en),
    .clear_flags(clr), .out(out_a), .out_valid(vld_a), .count(cnt_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  sample_fifo #(.WIDTH(8), .DEPTH(5)) u_dut_b (
    .clk(clk), .reset(reset), .in(din), .w_enable(w_en), .r_enable(r_en),
    .clear_flags(clr), .out(out_b), .out_valid(vld_b), .count(cnt_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int sel   = 0;  // 0: DEPTH=3 instance, 1: DEPTH=5 instance

  // Observed outputs of the instance under test.
  logic signed [7:0] o_out;
  logic              o_valid, o_full, o_empty, o_af, o_ae, o_ovf, o_unf;
  int                o_cnt;
  always_comb begin
    if (sel == 1) begin
      o_out = out_b; o_valid = vld_b; o_cnt = int'(cnt_b);
      o_full = full_b; o_empty = empty_b; o_af = af_b; o_ae = ae_b;
      o_ovf = ovf_b; o_unf = unf_b;
    end else begin
      o_out = out_a; o_valid = vld_a; o_cnt = int'(cnt_a);
      o_full = full_a; o_empty = empty_a; o_af = af_a; o_ae = ae_a;
      o_ovf = ovf_a; o_unf = unf_a;
    end
  end

  // Reference model: a plain queue of samples plus last output and flags.
  int                m_q[$];
  int                m_depth = 3;
  logic signed [7:0] m_out;
  logic              m_valid, m_ovf, m_unf;

  function automatic void model_reset();
    m_q.delete();
    m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endfunction

  function automatic void model_edge(input logic w, input logic r,
                                     input logic c, input logic signed [7:0] d);
    bit is_full  = (m_q.size() == m_depth);
    bit is_empty = (m_q.size() == 0);
    bit rd = r && !is_empty;
    bit wr = w && (!is_full || rd);
    m_valid = rd;
    if (rd) m_out = 8'(m_q.pop_front());
    if (wr) m_q.push_back(int'(d));
    m_ovf = (w && !wr) || (m_ovf && !c);
    m_unf = (r && !rd) || (m_unf && !c);
  endfunction

  function automatic logic [18:0] exp_vec();
    int n = m_q.size();
    return {m_out, m_valid, 4'(n), n == m_depth, n == 0, n >= m_depth - 1,
            n <= 1, m_ovf, m_unf};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {o_out, o_valid, 4'(o_cnt), o_full, o_empty, o_af, o_ae, o_ovf, o_unf};
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model.
  task automatic cycle(input logic w, input logic r, input logic c,
                       input logic signed [7:0] d);
    w_en = w; r_en = r; clr = c; din = d;
    @(posedge clk);
    model_edge(w, r, c, d);
    #1;
    w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
  endtask

  task automatic apply_reset(input int inst);
    sel = inst;
    m_depth = (inst == 1) ? 5 : 3;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset(0);
    n_vec++;
    if (obs_vec() !== 19'b0000_0000_0_0000_0_1_0_1_0_0) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", obs_vec(), 19'b0000_0000_0_0000_0_1_0_1_0_0);
    end
  endtask

  task automatic test_fill_drain();
    int vals[3] = '{5, -3, 7};
    apply_reset(0);
    foreach (vals[i]) cycle(1'b1, 1'b0, 1'b0, 8'(vals[i]));
    n_vec++;
    if (o_cnt !== 3 || o_full !== 1'b1 || o_af !== 1'b1) begin
      n_err++;
      $display("FAIL fill: got count=%0d full=%b af=%b want count=3 full=1 af=1", o_cnt, o_full, o_af);
    end
    foreach (vals[i]) begin
      cycle(1'b0, 1'b1, 1'b0, 8'sd0);
      n_vec++;
      if (o_out !== 8'(vals[i]) || o_valid !== 1'b1) begin
        n_err++;
        $display("FAIL drain[%0d]: got out=%0d valid=%b want out=%0d valid=1", i, o_out, o_valid, vals[i]);
      end
    end
    n_vec++;
    if (obs_vec() !== exp_vec() || o_empty !== 1'b1) begin
      n_err++;
      $display("FAIL drain_end: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    int vals[3] = '{5, -3, 7};
    apply_reset(0);
    foreach (vals[i]) cycle(1'b1, 1'b0, 1'b0, 8'(vals[i]));
    cycle(1'b1, 1'b0, 1'b0, 8'sd9);
    n_vec++;
    if (o_ovf !== 1'b1 || o_cnt !== 3) begin
      n_err++;
      $display("FAIL overflow_set: got ovf=%b count=%0d want ovf=1 count=3", o_ovf, o_cnt);
    end
    foreach (vals[i]) begin
      cycle(1'b0, 1'b1, 1'b0, 8'sd0);
      n_vec++;
      if (o_out !== 8'(vals[i])) begin
        n_err++;
        $display("FAIL overflow_read[%0d]: got %0d want %0d", i, o_out, vals[i]);
      end
    end
    cycle(1'b0, 1'b1, 1'b0, 8'sd0);
    n_vec++;
    if (o_out !== 8'sd7 || o_valid !== 1'b0 || o_unf !== 1'b1) begin
      n_err++;
      $display("FAIL dropped_sample: got out=%0d valid=%b unf=%b want out=7 valid=0 unf=1", o_out, o_valid, o_unf);
    end
    cycle(1'b0, 1'b0, 1'b1, 8'sd0);
    n_vec++;
    if (o_ovf !== 1'b0 || o_unf !== 1'b0) begin
      n_err++;
      $display("FAIL clear_flags: got ovf=%b unf=%b want 0 0", o_ovf, o_unf);
    end
    // Clear together with a new error: the flag must stay set.
    cycle(1'b0, 1'b1, 1'b1, 8'sd0);
    n_vec++;
    if (o_unf !== 1'b1) begin
      n_err++;
      $display("FAIL set_wins: got unf=%b want 1", o_unf);
    end
  endtask

  task automatic test_full_rw();
    int vals[3] = '{-3, 7, 9};
    apply_reset(0);
    cycle(1'b1, 1'b0, 1'b0, 8'sd5);
    cycle(1'b1, 1'b0, 1'b0, -8'sd3);
    cycle(1'b1, 1'b0, 1'b0, 8'sd7);
    cycle(1'b1, 1'b1, 1'b0, 8'sd9);
    n_vec++;
    if (o_out !== 8'sd5 || o_cnt !== 3 || o_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL full_rw: got out=%0d count=%0d ovf=%b want out=5 count=3 ovf=0", o_out, o_cnt, o_ovf);
    end
    foreach (vals[i]) begin
      cycle(1'b0, 1'b1, 1'b0, 8'sd0);
      n_vec++;
      if (o_out !== 8'(vals[i])) begin
        n_err++;
        $display("FAIL wrap_read[%0d]: got %0d want %0d", i, o_out, vals[i]);
      end
    end
  endtask

  // Continues from test_full_rw: buffer empty, out holds 9.
  task automatic test_empty_rw();
    cycle(1'b1, 1'b1, 1'b0, 8'sd4);
    n_vec++;
    if (o_unf !== 1'b1 || o_out !== 8'sd9 || o_valid !== 1'b0 || o_cnt !== 1) begin
      n_err++;
      $display("FAIL empty_rw: got unf=%b out=%0d valid=%b count=%0d want 1 9 0 1", o_unf, o_out, o_valid, o_cnt);
    end
    cycle(1'b0, 1'b1, 1'b0, 8'sd0);
    n_vec++;
    if (o_out !== 8'sd4 || o_valid !== 1'b1) begin
      n_err++;
      $display("FAIL empty_rw_read: got out=%0d valid=%b want 4 1", o_out, o_valid);
    end
  endtask

  task automatic test_depth5();
    int exp_q[$];
    logic signed [7:0] d;
    apply_reset(1);
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      exp_q.push_back(int'(d));
      cycle(1'b1, 1'b0, 1'b0, d);
    end
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      exp_q.push_back(int'(d));
      cycle(1'b1, 1'b0, 1'b0, d);
      if (i % 4 == 0) begin
        d = 8'($urandom);
        exp_q.push_back(int'(d));
        cycle(1'b1, 1'b0, 1'b0, d);
      end
      cycle(1'b0, 1'b1, 1'b0, 8'sd0);
      n_vec++;
      if (o_out !== 8'(exp_q.pop_front()) || o_cnt > 5 || obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL depth5[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midcycle();
    apply_reset(0);
    cycle(1'b1, 1'b0, 1'b0, 8'sd21);
    cycle(1'b1, 1'b1, 1'b0, 8'sd22);
    cycle(1'b1, 1'b0, 1'b0, 8'sd23);
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (obs_vec() !== 19'b0000_0000_0_0000_0_1_0_1_0_0) begin
      n_err++;
      $display("FAIL reset_midcycle: got %h want %h", obs_vec(), 19'b0000_0000_0_0000_0_1_0_1_0_0);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, -8'sd11);
    cycle(1'b0, 1'b1, 1'b0, 8'sd0);
    n_vec++;
    if (o_out !== -8'sd11 || o_valid !== 1'b1 || o_cnt !== 0) begin
      n_err++;
      $display("FAIL after_reset: got out=%0d valid=%b count=%0d want -11 1 0", o_out, o_valid, o_cnt);
    end
  endtask

  task automatic test_random(input int inst, input int n);
    logic w, r, c;
    apply_reset(inst);
    for (int i = 0; i < n; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 15) == 0);
      cycle(w, r, c, 8'($urandom));
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random%0d[%0d]: got %h want %h", inst, i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; din = '0; w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_depth5();
    test_reset_midcycle();
    test_random(0, 300);
    test_random(1, 300);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sample_fifo.md
# sample_fifo

Parametrised signed-sample FIFO, next generation of the team's circular sample buffer. Adds full/empty protection, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and an output-valid strobe. Non-power-of-two depths are supported. It sits between sample producers (ADC front-end, filter stages) and consumers running on the same clock.

## Interface
- WIDTH, 8: sample width in bits, signed.
- DEPTH, 3: number of storage entries; any value ≥ 2, not restricted to powers of two.
- ALMOST_FULL, DEPTH-1: almost_full asserted when count ≥ this value.
- ALMOST_EMPTY, 1: almost_empty asserted when count ≤ this value.

- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- in  in  WIDTH signed  write data.
- w_enable  in  1  write request.
- r_enable  in  1  read request.
- clear_flags  in  1  synchronous clear of overflow/underflow.
- out  out  WIDTH signed  registered read data.
- out_valid  out  1  one-cycle strobe: out was loaded by an accepted read on the previous edge.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  occupancy status.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- Read accepted = r_enable && !empty. Write accepted = w_enable && (!full || read accepted).
- Accepted write stores in at producer pointer. Accepted read loads out from consumer pointer. Each pointer advances by one. Pointers wrap from DEPTH-1 to 0.
- count += accepted write − accepted read.
- Full with r_enable and w_enable both high: both accepted, count unchanged, no overflow.
- Empty with r_enable and w_enable both high: write accepted, read rejected (no fall-through), underflow set, out holds.
- w_enable while full and no accepted read: data dropped, pointers unchanged, overflow set.
- r_enable while empty: out holds, out_valid low, underflow set.
- overflow/underflow stay high until clear_flags or reset. If clear_flags and a new error occur in the same cycle, the flag remains set (set wins).
- out holds its last value when no read is accepted.
- Storage array is not reset; its contents are unobservable until written.

## Timing
- Reset values: out=0, out_valid=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, both pointers 0.
- Reset asserted mid-operation discards all contents at once. The first edge after release behaves as from the empty state.
- All status outputs are registered and reflect the occupancy after the most recent edge; no combinational path from inputs to outputs.
- Write at edge k → empty deasserts after edge k. A read requested in cycle k+1 loads out at edge k+1. Minimum write-to-out latency is 2 edges.
- Read latency: out and out_valid update at the edge that accepts the read, i.e. 1 cycle after r_enable is sampled.
- Sustained throughput: one read plus one write per cycle at any occupancy 1..DEPTH.

## Structure
- Shared package sample_fifo_pkg: function next_ptr(ptr, depth) for wrap-around increment, plus localparams PTR_W = $clog2(DEPTH) (minimum 1) and CNT_W = $clog2(DEPTH+1).
- One sub-module, fifo_wrap_ptr: parametrised pointer with enable, wrap at DEPTH-1 and async active-low reset. Instantiated twice, once as producer pointer and once as consumer pointer.
- Top level holds the storage array, count register, status flag registers and error flags.

## Test plan
- Reset then write 5, −3, 7 (DEPTH=3) → full=1, count=3, almost_full=1. Three reads → out 5, −3, 7 on consecutive edges, out_valid high 3 cycles, empty=1.
- Full, fourth write of 9 with no read → overflow=1, count=3. Reads return 5, −3, 7; 9 never appears. clear_flags → overflow=0.
- Full, simultaneous read and write of 9 → out=5, count stays 3. Later reads return −3, 7, 9 (wrap-around verified).
- Empty, simultaneous read and write of 4 → underflow=1, out holds previous value, out_valid=0, count=1. Next read → out=4.
- DEPTH=5 instance: 12 interleaved write/read pairs → order preserved across two pointer wraps, count never exceeds 5.
- Reset pulled low mid-cycle with count=2 → all outputs at reset values before the next edge. After release, a write then a read returns the new datum.
